// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline payload types and memory-access stage defaults
package cpu_pkg;
  localparam int          MA_TIMEOUT_CYC = 256;
  localparam logic [31:0] MA_POISON      = 32'hDEAD_BEEF;
  typedef struct packed {
    logic isLd;
    logic isSt;
    logic isWb;
  } ctrl_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] aluresult;
    logic [31:0] op2;
    logic [31:0] instr;
    ctrl_t       ctrl;
  } Ex_Ma_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] aluresult;
    logic [31:0] ldresult;
    logic [31:0] instr;
    ctrl_t       ctrl;
  } Ma_Rw_t;
  typedef enum logic [1:0] {IDLE, REQ, RD_WAIT} ma_state_e;
endpackage

// File: rtl/ma_timer.sv
// ma_timer: saturating wait counter flagging expiry at TIMEOUT_CYC-1
module ma_timer #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT_CYC) + 1;
  logic [W-1:0] r_cnt;
  assign o_expired = r_cnt == W'(TIMEOUT_CYC - 1);
  // count waiting cycles and hold once expiry is reached
  always_ff @(posedge i_clk)
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + W'(1);
endmodule

// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage with one outstanding data-memory request
module ma_stage
  import cpu_pkg::*;
#(
  parameter int          TIMEOUT_CYC = MA_TIMEOUT_CYC,
  parameter logic [31:0] POISON      = MA_POISON
) (
  input  logic        Clk,
  input  logic        Rst,
  input  Ex_Ma_t      Ex_Payld_i,
  input  logic        Ex_Valid_i,
  output logic        Ex_Ready_o,
  output Ma_Rw_t      Ma_Payld_o,
  output logic        Ma_Valid_o,
  input  logic        Ma_Ready_i,
  output logic        Dmem_Req_o,
  output logic        Dmem_We_o,
  output logic [31:0] Dmem_Addr_o,
  output logic [31:0] Dmem_Wdata_o,
  input  logic        Dmem_Gnt_i,
  input  logic        Dmem_Rvalid_i,
  input  logic [31:0] Dmem_Rdata_i,
  output logic        Misalign_o,
  output logic        Timeout_o
);
  ma_state_e   r_state, w_next;
  Ex_Ma_t      r_cap;
  logic        w_accept, w_mem, w_mis, w_start, w_expired;
  logic        w_tmr_clr, w_tmr_en, w_load, w_timeout, w_use_cap;
  logic [31:0] w_ldres;

  assign Ex_Ready_o   = (r_state == IDLE) && (!Ma_Valid_o || Ma_Ready_i);
  assign w_accept     = Ex_Valid_i && Ex_Ready_o;
  assign w_mem        = Ex_Payld_i.ctrl.isLd || Ex_Payld_i.ctrl.isSt;
  assign w_mis        = w_mem && |Ex_Payld_i.aluresult[1:0];
  assign w_start      = w_accept && w_mem && !w_mis;
  assign Dmem_We_o    = !r_cap.ctrl.isLd;
  assign Dmem_Addr_o  = r_cap.aluresult;
  assign Dmem_Wdata_o = r_cap.op2;

  ma_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clk    (Clk),
    .i_rst    (Rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expired(w_expired)
  );

  // state register
  always_ff @(posedge Clk) r_state <= Rst ? IDLE : w_next;

  // next state: a grant or read data always wins over a coincident expiry
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? REQ : IDLE;
      REQ:     w_next = Dmem_Gnt_i ? (r_cap.ctrl.isLd ? RD_WAIT : IDLE) : (w_expired ? IDLE : REQ);
      RD_WAIT: w_next = (Dmem_Rvalid_i || w_expired) ? IDLE : RD_WAIT;
      default: w_next = IDLE;
    endcase
  end

  // outputs: memory request, timer control and output-slot load decision
  always_comb begin
    Dmem_Req_o = r_state == REQ;
    w_tmr_en   = r_state != IDLE;
    w_tmr_clr  = (r_state == IDLE) || (r_state == REQ && Dmem_Gnt_i);
    w_use_cap  = r_state != IDLE;
    w_load     = 1'b0;
    w_ldres    = '0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        w_load  = w_accept && (!w_mem || w_mis);
        w_ldres = (w_mis && Ex_Payld_i.ctrl.isLd) ? POISON : '0;
      end
      REQ: begin
        w_timeout = !Dmem_Gnt_i && w_expired;
        w_load    = (Dmem_Gnt_i && !r_cap.ctrl.isLd) || w_timeout;
        w_ldres   = (w_timeout && r_cap.ctrl.isLd) ? POISON : '0;
      end
      RD_WAIT: begin
        w_timeout = !Dmem_Rvalid_i && w_expired;
        w_load    = Dmem_Rvalid_i || w_expired;
        w_ldres   = Dmem_Rvalid_i ? Dmem_Rdata_i : POISON;
      end
      default: w_load = 1'b0;
    endcase
  end

  // capture register holds the payload of the access in flight
  always_ff @(posedge Clk)
    if (Rst) r_cap <= '0;
    else if (w_start) r_cap <= Ex_Payld_i;

  // sticky error flags, cleared only by reset
  always_ff @(posedge Clk) begin
    Misalign_o <= !Rst && (Misalign_o || (w_accept && w_mis));
    Timeout_o  <= !Rst && (Timeout_o || w_timeout);
  end

  // output slot: reload wins, otherwise drain on ready and hold under backpressure
  always_ff @(posedge Clk)
    if (Rst) begin
      Ma_Valid_o <= 1'b0;
      Ma_Payld_o <= '0;
    end else if (w_load) begin
      Ma_Valid_o           <= 1'b1;
      Ma_Payld_o.pc        <= w_use_cap ? r_cap.pc : Ex_Payld_i.pc;
      Ma_Payld_o.aluresult <= w_use_cap ? r_cap.aluresult : Ex_Payld_i.aluresult;
      Ma_Payld_o.ldresult  <= w_ldres;
      Ma_Payld_o.instr     <= w_use_cap ? r_cap.instr : Ex_Payld_i.instr;
      Ma_Payld_o.ctrl      <= w_use_cap ? r_cap.ctrl : Ex_Payld_i.ctrl;
    end else if (Ma_Ready_i) Ma_Valid_o <= 1'b0;
endmodule

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory Access stage of the 5-stage in-order pipeline (IF/OF/EX/MA/RW).
- Consumes the EX→MA payload (Ex_Ma_t) through a valid/ready handshake.
- Issues load and store requests to the data-memory port using a req/gnt/rvalid protocol, with one request outstanding at a time.
- Produces the MA→RW payload (Ma_Rw_t) through a registered valid/ready output toward the RW stage.

Parameters:
- TIMEOUT_CYC, 256: cycles to wait for Dmem_Gnt_i or Dmem_Rvalid_i before aborting the access.
- POISON, 32'hDEAD_BEEF: ldresult returned on an aborted or misaligned load.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous reset, active-high.
- Ex_Payld_i  in  Ex_Ma_t  pc, aluresult, op2, instr, ctrl (ctrl.isLd, ctrl.isSt used here).
- Ex_Valid_i  in  1  EX payload valid.
- Ex_Ready_o  out  1  MA accepts the payload this cycle.
- Ma_Payld_o  out  Ma_Rw_t  pc, aluresult, ldresult, instr, ctrl.
- Ma_Valid_o  out  1  RW payload valid.
- Ma_Ready_i  in  1  RW accepts.
- Dmem_Req_o  out  1  memory request.
- Dmem_We_o  out  1  1 = store.
- Dmem_Addr_o  out  32  byte address (= aluresult).
- Dmem_Wdata_o  out  32  store data (= op2).
- Dmem_Gnt_i  in  1  request accepted.
- Dmem_Rvalid_i  in  1  load data valid.
- Dmem_Rdata_i  in  32  load data.
- Misalign_o  out  1  sticky: a load/store had aluresult[1:0] != 0.
- Timeout_o  out  1  sticky: an access hit TIMEOUT_CYC.

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - state=IDLE; Ma_Valid_o=0; Dmem_Req_o=0; Misalign_o=0; Timeout_o=0; timer=0.
  - Ma_Payld_o and the internal capture register are cleared to '0.
  - Reset mid-access abandons the access. The memory port must tolerate the dropped request.
  - An Rvalid arriving after reset is ignored.
- Output slot: Ma_Valid_o/Ma_Payld_o are registers. They hold stable while Ma_Valid_o=1 && Ma_Ready_i=0, and clear when Ma_Ready_i=1 unless reloaded in the same cycle.
- Ex_Ready_o = (state==IDLE) && (!Ma_Valid_o || Ma_Ready_i). The output slot is therefore guaranteed empty whenever state != IDLE.
- Acceptance: accept = Ex_Valid_i && Ex_Ready_o.
- IDLE, on accept:
  - Neither isLd nor isSt: load the output slot with ldresult=0. Ma_Valid_o=1 next cycle (latency 1). Stay in IDLE, so back-to-back throughput is 1/cycle.
  - isLd or isSt with aluresult[1:0]!=0: no memory request. Set Misalign_o. Load the output slot with ldresult = isLd ? POISON : 0. Stay in IDLE.
  - Aligned isLd/isSt: capture the payload, go to REQ, timer=0.
- REQ:
  - Dmem_Req_o=1. Addr, We and Wdata are driven from the captured payload and held stable until grant.
  - On Dmem_Gnt_i:
    - Store: output slot loaded with ldresult=0; go to IDLE.
    - Load: go to RD_WAIT, timer=0.
  - Dmem_Req_o drops the cycle after grant.
- RD_WAIT:
  - Dmem_Req_o=0.
  - On Dmem_Rvalid_i: output slot loaded with ldresult=Dmem_Rdata_i; go to IDLE.
  - Rvalid is sampled only in RD_WAIT. The earliest is the cycle after grant; Rvalid asserted in the grant cycle is ignored.
- Timer:
  - Counts each cycle spent in REQ or RD_WAIT without the awaited event.
  - At timer==TIMEOUT_CYC-1 with no event:
    - Set Timeout_o.
    - Deassert Dmem_Req_o.
    - Output slot loaded with ldresult = load ? POISON : 0.
    - Go to IDLE.
  - Timer width is $clog2(TIMEOUT_CYC)+1. The timer saturates and never wraps.
- Simultaneous events: if grant/rvalid and timeout occur in the same cycle, the event wins and no timeout is flagged.
- Output slot contents: pc, aluresult, instr and ctrl are passed through from the captured (or directly accepted) payload.
- Ma_Payld_o must not change while Ma_Valid_o=1 && !Ma_Ready_i.
- Sticky flags clear only on Rst.

Decomposition:
- Shared package cpu_pkg:
  - Ma_Rw_t struct: pc[31:0], aluresult[31:0], ldresult[31:0], instr[31:0], ctrl.
  - ma_state_e enum {IDLE, REQ, RD_WAIT}.
  - Default constants MA_TIMEOUT_CYC and MA_POISON.
  - Ex_Ma_t already lives there.
- One sub-module, ma_timer: a saturating counter with clear/enable inputs and an expired output at TIMEOUT_CYC-1.
- The FSM, capture register and output slot stay in ma_stage.

Test Plan:
- ALU stream: 4 back-to-back non-memory ops with aluresult 1,2,3,4 and Ma_Ready_i=1 → Ma_Valid_o high 4 consecutive cycles starting 1 cycle after the first accept, ldresult=0 each, Dmem_Req_o never asserted.
- Load: aluresult=32'h100, isLd; Gnt after 2 cycles; Rvalid with Rdata=32'hCAFE_F00D 3 cycles after grant → Dmem_Addr_o=32'h100, We=0, req stable until grant; Ma_Payld_o.ldresult=32'hCAFE_F00D one cycle after Rvalid; Ex_Ready_o=0 throughout.
- Store plus backpressure: store to 32'h40 with op2=32'h55, Gnt immediate, Ma_Ready_i=0 for 5 cycles → We=1, Wdata=32'h55; Ma_Valid_o held with a stable payload; Ex_Ready_o=0 until Ma_Ready_i=1, then accepts the next op in that same cycle.
- Misaligned load: aluresult=32'h102 → no Dmem_Req_o; Misalign_o=1; ldresult=POISON after 1 cycle.
- Timeout: TIMEOUT_CYC=8, load, Gnt never arrives → Dmem_Req_o high for exactly 8 cycles; Timeout_o=1; ldresult=32'hDEAD_BEEF; a second access with Gnt at cycle 8 coincident with expiry completes normally.
- Reset mid-access: Rst=1 while in RD_WAIT, then a stray Rvalid after reset → all outputs at reset values; stray Rvalid produces no Ma_Valid_o.
